mvu_job_ctrl: RTL and testbench

//  Job sequencer for one MVU lane: latches job config on start, clears and steps the input/weight

---
 rtl/mvu_pkg.sv | 14 +
 rtl/mvu_delay_line.sv | 28 ++
 rtl/mvu_job_ctrl.sv | 143 ++++++++++++++
 tb/tb_mvu_job_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared types and defaults for the MVU lane job controller.
package mvu_pkg;

  localparam int unsigned BPREC_DEFAULT = 6;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mvu_delay_line.sv
// Fixed-depth shift register with async reset and synchronous flush to zero.
module mvu_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/mvu_job_ctrl.sv
// Job sequencer for one MVU lane: clears and steps the AGU, drains the RAM+MAC
// pipeline, and emits pipeline-aligned valid / shift-accumulator load strobes.
module mvu_job_ctrl
  import mvu_pkg::*;
#(
  parameter int unsigned BPREC    = BPREC_DEFAULT,
  parameter int unsigned BCNT     = 32,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic [BCNT-1:0]  cfg_steps,
  input  logic [BPREC-1:0] cfg_iprec,
  input  logic [BPREC-1:0] cfg_wprec,
  input  logic             acc_last_in,
  output logic             agu_clr,
  output logic             agu_en,
  output logic [BPREC-1:0] iprec_q,
  output logic [BPREC-1:0] wprec_q,
  output logic             mac_valid,
  output logic             shacc_load,
  output logic             busy,
  output logic             done,
  output logic             start_err
);

  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_e           r_state, w_state_d;
  logic [BCNT-1:0]  r_cnt, w_cnt_d;
  logic [DW-1:0]    r_dcnt, w_dcnt_d;
  logic [BPREC-1:0] r_iprec, w_iprec_d;
  logic [BPREC-1:0] r_wprec, w_wprec_d;
  logic             r_abort_clr;
  logic             r_busy, r_done, r_start_err;
  logic             w_abort, w_agu_en, w_agu_clr, w_start_err;
  logic [1:0]       w_dl_out;

  assign w_abort = abort && (r_state != StIdle);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_dcnt_d    = r_dcnt;
    w_iprec_d   = r_iprec;
    w_wprec_d   = r_wprec;
    w_agu_en    = 1'b0;
    w_agu_clr   = 1'b0;
    w_start_err = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Generator clear owed from an abort in the previous cycle.
        w_agu_clr = r_abort_clr;
        if (start) begin
          w_iprec_d = cfg_iprec;
          w_wprec_d = cfg_wprec;
          w_cnt_d   = cfg_steps;
          w_state_d = StClear;
        end
      end
      StClear: begin
        w_agu_clr = 1'b1;
        w_state_d = (r_cnt != '0) ? StRun : StDone;
      end
      StRun: begin
        w_agu_en = ~stall & ~w_abort;
        if (w_agu_en && (r_cnt != '0)) begin
          w_cnt_d = r_cnt - BCNT'(1);
          if (r_cnt == BCNT'(1)) begin
            w_state_d = StDrain;
            w_dcnt_d  = DW'(PIPE_LAT);
          end
        end
      end
      StDrain: begin
        if (r_dcnt == DW'(1)) w_state_d = StDone;
        else                  w_dcnt_d  = r_dcnt - DW'(1);
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (r_state != StIdle) begin
      w_start_err = start & ~w_abort;
      if (w_abort) w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_iprec     <= '0;
      r_wprec     <= '0;
      r_abort_clr <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_dcnt      <= w_dcnt_d;
      r_iprec     <= w_iprec_d;
      r_wprec     <= w_wprec_d;
      r_abort_clr <= w_abort;
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone) && (r_state != StDone);
      r_start_err <= w_start_err;
    end
  end

  // Bit 1 tracks shacc_load, bit 0 tracks mac_valid.
  mvu_delay_line #(
    .WIDTH(2),
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(w_abort),
    .i_din  ({w_agu_en & acc_last_in, w_agu_en}),
    .o_dout (w_dl_out)
  );

  assign agu_en     = w_agu_en;
  assign agu_clr    = w_agu_clr;
  assign iprec_q    = r_iprec;
  assign wprec_q    = r_wprec;
  assign mac_valid  = w_dl_out[0];
  assign shacc_load = w_dl_out[1];
  assign busy       = r_busy;
  assign done       = r_done;
  assign start_err  = r_start_err;

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Scoreboard bench for mvu_job_ctrl: directed jobs push expected strobe vectors
// and status snapshots; a negedge monitor pops and compares them.
module tb_mvu_job_ctrl;

  localparam int unsigned BPREC    = 6;
  localparam int unsigned BCNT     = 32;
  localparam int unsigned PIPE_LAT = 3;

  // Strobe vector bits: {agu_clr, agu_en, mac_valid, shacc_load, done, start_err}
  typedef struct {
    int         cyc;
    logic [5:0] v;
  } ev_t;

  typedef struct {
    int               cyc;
    logic             busy;
    logic [BPREC-1:0] ip;
    logic [BPREC-1:0] wp;
  } st_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stall = 1'b0;
  logic             acc_last_in = 1'b0;
  logic [BCNT-1:0]  cfg_steps = '0;
  logic [BPREC-1:0] cfg_iprec = '0;
  logic [BPREC-1:0] cfg_wprec = '0;
  logic             agu_clr, agu_en, mac_valid, shacc_load, busy, done, start_err;
  logic [BPREC-1:0] iprec_q, wprec_q;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  finish_req = 1'b0;
  bit  mon_done = 1'b0;
  ev_t evq[$];
  st_t stq[$];
  ev_t e;
  st_t s;
  logic [5:0] act;
  int  t;

  mvu_job_ctrl #(
    .BPREC   (BPREC),
    .BCNT    (BCNT),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .stall      (stall),
    .cfg_steps  (cfg_steps),
    .cfg_iprec  (cfg_iprec),
    .cfg_wprec  (cfg_wprec),
    .acc_last_in(acc_last_in),
    .agu_clr    (agu_clr),
    .agu_en     (agu_en),
    .iprec_q    (iprec_q),
    .wprec_q    (wprec_q),
    .mac_valid  (mac_valid),
    .shacc_load (shacc_load),
    .busy       (busy),
    .done       (done),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [5:0] v);
    ev_t x;
    x.cyc = c;
    x.v   = v;
    evq.push_back(x);
  endtask

  task automatic push_s(input int c, input logic b, input int ip, input int wp);
    st_t x;
    x.cyc  = c;
    x.busy = b;
    x.ip   = BPREC'(ip);
    x.wp   = BPREC'(wp);
    stq.push_back(x);
  endtask

  // Issues a one-cycle start; returns the cycle in which start was high.
  task automatic run_start(input int steps, input int ip, input int wp, output int ts);
    ts        = cyc;
    cfg_steps = BCNT'(steps);
    cfg_iprec = BPREC'(ip);
    cfg_wprec = BPREC'(wp);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      act = {agu_clr, agu_en, mac_valid, shacc_load, done, start_err};
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_event: cycle %0d actual none required %b", e.cyc, e.v);
      end
      if (act != '0) begin
        n_checks++;
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          n_errors++;
          $display("FAIL unexpected_event: cycle %0d actual %b required none", cyc, act);
        end else begin
          e = evq.pop_front();
          if (e.v != act) begin
            n_errors++;
            $display("FAIL strobes: cycle %0d actual %b required %b", cyc, act, e.v);
          end
        end
      end
      while (stq.size() > 0 && stq[0].cyc <= cyc) begin
        s = stq.pop_front();
        n_checks++;
        if (s.cyc != cyc) begin
          n_errors++;
          $display("FAIL status_skipped: cycle %0d not sampled", s.cyc);
        end else if (busy !== s.busy || iprec_q !== s.ip || wprec_q !== s.wp) begin
          n_errors++;
          $display("FAIL status: cycle %0d actual busy=%b ip=%0d wp=%0d required busy=%b ip=%0d wp=%0d",
                   cyc, busy, iprec_q, wprec_q, s.busy, s.ip, s.wp);
        end
      end
      if (finish_req && !mon_done) begin
        n_checks++;
        if (evq.size() != 0 || stq.size() != 0) begin
          n_errors++;
          $display("FAIL leftover: actual %0d events %0d status pending required 0",
                   evq.size(), stq.size());
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    push_s(cyc, 1'b0, 0, 0);
    tick();

    // Abort while idle must produce no strobes.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // 5-step job, no stall.
    run_start(5, 3, 4, t);
    push(t+1, 6'b100000);
    for (int k = 2; k <= 4; k++) push(t+k, 6'b010000);
    push(t+5, 6'b011000);
    push(t+6, 6'b011000);
    for (int k = 7; k <= 9; k++) push(t+k, 6'b001000);
    push(t+10, 6'b000010);
    push_s(t+1, 1'b1, 3, 4);
    push_s(t+10, 1'b1, 3, 4);
    push_s(t+11, 1'b0, 3, 4);
    repeat (12) tick();

    // 4-step job, stall during two cycles after the 2nd step.
    run_start(4, 1, 1, t);
    push(t+1, 6'b100000);
    push(t+2, 6'b010000);
    push(t+3, 6'b010000);
    push(t+5, 6'b001000);
    push(t+6, 6'b011000);
    push(t+7, 6'b010000);
    push(t+9, 6'b001000);
    push(t+10, 6'b001000);
    push(t+11, 6'b000010);
    push_s(t+11, 1'b1, 1, 1);
    push_s(t+12, 1'b0, 1, 1);
    repeat (3) tick();
    stall = 1'b1;
    repeat (2) tick();
    stall = 1'b0;
    repeat (8) tick();

    // Zero-length job.
    run_start(0, 5, 6, t);
    push(t+1, 6'b100000);
    push(t+2, 6'b000010);
    push_s(t+2, 1'b1, 5, 6);
    push_s(t+3, 1'b0, 5, 6);
    repeat (3) tick();

    // 6-step job with accumulation boundaries on steps 3 and 6.
    run_start(6, 4, 4, t);
    push(t+1, 6'b100000);
    for (int k = 2; k <= 4; k++) push(t+k, 6'b010000);
    push(t+5, 6'b011000);
    push(t+6, 6'b011000);
    push(t+7, 6'b011100);
    push(t+8, 6'b001000);
    push(t+9, 6'b001000);
    push(t+10, 6'b001100);
    push(t+11, 6'b000010);
    repeat (3) tick();
    acc_last_in = 1'b1;
    tick();
    acc_last_in = 1'b0;
    repeat (2) tick();
    acc_last_in = 1'b1;
    tick();
    acc_last_in = 1'b0;
    repeat (5) tick();

    // Abort in RUN after two steps.
    run_start(8, 2, 3, t);
    push(t+1, 6'b100000);
    push(t+2, 6'b010000);
    push(t+3, 6'b010000);
    push(t+5, 6'b100000);
    push_s(t+4, 1'b1, 2, 3);
    push_s(t+5, 1'b0, 2, 3);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (6) tick();

    // Start while running: flagged and ignored.
    run_start(3, 2, 5, t);
    push(t+1, 6'b100000);
    push(t+2, 6'b010000);
    push(t+3, 6'b010000);
    push(t+4, 6'b010001);
    for (int k = 5; k <= 7; k++) push(t+k, 6'b001000);
    push(t+8, 6'b000010);
    push_s(t+5, 1'b1, 2, 5);
    push_s(t+9, 1'b0, 2, 5);
    repeat (2) tick();
    start     = 1'b1;
    cfg_iprec = 6'd7;
    tick();
    start     = 1'b0;
    repeat (7) tick();

    // Start in DONE is rejected; start on the following IDLE cycle is accepted.
    run_start(0, 1, 2, t);
    push(t+1, 6'b100000);
    push(t+2, 6'b000010);
    push(t+3, 6'b000001);
    push(t+4, 6'b100000);
    push(t+5, 6'b000010);
    push_s(t+3, 1'b0, 1, 2);
    push_s(t+4, 1'b1, 3, 2);
    tick();
    start     = 1'b1;
    cfg_iprec = 6'd9;
    tick();
    cfg_iprec = 6'd3;
    tick();
    start     = 1'b0;
    repeat (4) tick();

    finish_req = 1'b1;
    wait (mon_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
